clk_divider_multi: RTL and testbench



---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_chan.sv | 57 +++++
 rtl/clk_divider_multi.sv | 56 +++++
 tb/tb_clk_divider_multi.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults and helpers for the multi-channel clock divider
package clk_div_pkg;

    localparam int DIV_W_DEF = 27;
    localparam logic [DIV_W_DEF-1:0] DIV_RESET_DEF = '1;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel with deferred divisor update
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RESET = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             restart,
    input  logic             ld_valid,
    input  logic [DIV_W-1:0] ld_div,
    output logic             pend,
    output logic             clk_w,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] next_div;

    // Divisor to adopt at any reload point; a same-cycle load beats a pending one.
    assign next_div = ld_valid ? ld_div : (pend ? pend_div : div_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= DIV_RESET;
            div_reg  <= DIV_RESET;
            pend_div <= '0;
            pend     <= 1'b0;
            clk_w    <= 1'b0;
            tick     <= 1'b0;
        end else if (restart || !en) begin
            cnt     <= next_div;
            div_reg <= next_div;
            pend    <= 1'b0;
            clk_w   <= 1'b0;
            tick    <= 1'b0;
        end else if (cnt == '0) begin
            cnt     <= next_div;
            div_reg <= next_div;
            pend    <= 1'b0;
            clk_w   <= ~clk_w;
            tick    <= 1'b1;
        end else begin
            cnt  <= cnt - DIV_W'(1);
            tick <= 1'b0;
            if (ld_valid) begin
                pend     <= 1'b1;
                pend_div <= ld_div;
            end
        end
    end

endmodule

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - NCH-channel programmable clock divider with config handshake
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int               NCH       = 4,
    parameter int               DIV_W     = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RESET = {DIV_W{1'b1}},
    localparam int              CH_W      = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync_restart,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_chan,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [NCH-1:0]   clk_w,
    output logic [NCH-1:0]   tick
);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] ld_valid;

    // Out-of-range channels stay ready so such requests drain harmlessly.
    always_comb begin
        cfg_ready = 1'b1;
        ld_valid  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            ld_valid[i] = cfg_valid && cfg_ready && (cfg_chan == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en[g]),
            .restart  (sync_restart),
            .ld_valid (ld_valid[g]),
            .ld_div   (cfg_div),
            .pend     (pend[g]),
            .clk_w    (clk_w[g]),
            .tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - self-checking bench for clk_divider_multi
module tb_clk_divider_multi;

    localparam int NCH   = 3;
    localparam int DIV_W = 4;
    localparam int CH_W  = 2;
    localparam int D_RST = 15;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NCH-1:0]   en = '0;
    logic             sync_restart = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_chan = '0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [NCH-1:0]   clk_w;
    logic [NCH-1:0]   tick;

    clk_divider_multi #(
        .NCH   (NCH),
        .DIV_W (DIV_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_chan     (cfg_chan),
        .cfg_div      (cfg_div),
        .clk_w        (clk_w),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: each channel is a half-period of (D+1) cycles; left = cycles until the next visible toggle.
    int m_div  [NCH];
    int m_pdiv [NCH];
    int m_left [NCH];
    bit m_pend [NCH];
    bit m_w    [NCH];
    bit m_t    [NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = D_RST;
            m_pdiv[i] = 0;
            m_left[i] = D_RST + 1;
            m_pend[i] = 1'b0;
            m_w[i]    = 1'b0;
            m_t[i]    = 1'b0;
        end
    endfunction

    function automatic bit exp_ready(input int ch);
        return (ch >= NCH) ? 1'b1 : !m_pend[ch];
    endfunction

    function automatic logic [NCH-1:0] exp_w();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_w[i];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_t();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_t[i];
        return v;
    endfunction

    function automatic void model_step(input logic [NCH-1:0] e, input bit rs, input bit acc,
                                       input int ch, input int d);
        for (int i = 0; i < NCH; i++) begin
            bit a;
            int nd;
            a  = acc && (ch == i);
            nd = a ? d : (m_pend[i] ? m_pdiv[i] : m_div[i]);
            if (rs || !e[i]) begin
                m_div[i]  = nd;
                m_pend[i] = 1'b0;
                m_left[i] = nd + 1;
                m_w[i]    = 1'b0;
                m_t[i]    = 1'b0;
            end else if (m_left[i] == 1) begin
                m_w[i]    = !m_w[i];
                m_t[i]    = 1'b1;
                m_div[i]  = nd;
                m_pend[i] = 1'b0;
                m_left[i] = nd + 1;
            end else begin
                m_left[i] = m_left[i] - 1;
                m_t[i]    = 1'b0;
                if (a) begin
                    m_pend[i] = 1'b1;
                    m_pdiv[i] = d;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive just after negedge, step model at posedge, check at next negedge.
    task automatic cyc(input logic [NCH-1:0] e, input bit rs, input bit v, input int ch, input int d);
        bit acc;
        en           = e;
        sync_restart = rs;
        cfg_valid    = v;
        cfg_chan     = CH_W'(ch);
        cfg_div      = DIV_W'(d);
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready(ch)));
        acc = v && exp_ready(ch);
        @(posedge clk);
        model_step(e, rs, acc, ch, d);
        @(negedge clk);
        check("clk_w", 32'(clk_w), 32'(exp_w()));
        check("tick", 32'(tick), 32'(exp_t()));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_clk_w", 32'(clk_w), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        reset_n = 1'b1;

        // ch0 D=3 loaded while disabled, then run
        cyc(3'b000, 0, 1, 0, 3);
        repeat (20) cyc(3'b001, 0, 0, 0, 0);

        // divisor change mid half-period waits for terminal count
        cyc(3'b001, 0, 1, 0, 1);
        repeat (12) cyc(3'b001, 0, 0, 0, 0);

        // ch0 D=2, ch1 D=5, then phase-align
        cyc(3'b000, 0, 1, 0, 2);
        cyc(3'b000, 0, 1, 1, 5);
        repeat (7) cyc(3'b011, 0, 0, 0, 0);
        cyc(3'b011, 1, 0, 0, 0);
        repeat (14) cyc(3'b011, 0, 0, 0, 0);

        // ch1 D=0 then disable it
        cyc(3'b011, 0, 1, 1, 0);
        repeat (12) cyc(3'b011, 0, 0, 1, 0);
        repeat (4) cyc(3'b001, 0, 0, 1, 0);

        // out-of-range channel is accepted and dropped
        repeat (4) cyc(3'b001, 0, 1, 3, 7);

        // cfg accept coinciding with terminal count
        for (int k = 0; k < 40 && m_left[0] != 1; k++) cyc(3'b001, 0, 0, 0, 0);
        cyc(3'b001, 0, 1, 0, 4);
        repeat (12) cyc(3'b001, 0, 0, 0, 0);

        // cfg accept coinciding with sync_restart
        cyc(3'b011, 1, 1, 1, 2);
        repeat (8) cyc(3'b011, 0, 0, 0, 0);

        // asynchronous reset mid-count with a pending config
        for (int k = 0; k < 40 && !(m_w[0] && m_left[0] > 2); k++) cyc(3'b001, 0, 0, 0, 0);
        cyc(3'b001, 0, 1, 0, 6);
        en           = 3'b001;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_chan     = '0;
        @(posedge clk);
        model_step(3'b001, 0, 0, 0, 0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_clk_w", 32'(clk_w), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_cfg_ready", 32'(cfg_ready), 32'd1);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) cyc(3'b001, 0, 0, 0, 0);

        // randomized traffic
        begin
            logic [NCH-1:0] re;
            re = 3'b111;
            for (int n = 0; n < 3000; n++) begin
                bit rs;
                bit v;
                for (int b = 0; b < NCH; b++)
                    if ($urandom_range(0, 15) == 0) re[b] = !re[b];
                rs = ($urandom_range(0, 39) == 0);
                v  = ($urandom_range(0, 2) == 0);
                cyc(re, rs, v, int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
